// File: rtl/floating_point_adder.sv
// Multi-cycle IEEE-754 binary32 adder, round-to-nearest-even, with zero/inf/nan flags.
// Optional FPADD_FTZ_EN: flush denormal inputs and results to signed zero.
//
// state | meaning
// IDLE  | waiting for Go, captures operands
// ALIGN | unpack, pick big operand, align small significand with G/R/S
// ADD   | add or subtract magnitudes
// NORM  | carry shift right or limited leading-zero shift left
// ROUND | round to nearest even, build packed result or special value
// DONE  | publish Result and flags, pulse Ready
module floating_point_adder (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] AddendA,
  input  logic [31:0] AddendB,
  input  logic        Go,
  output logic [31:0] Result,
  output logic        Ready,
  output logic        Zero,
  output logic        Inf,
  output logic        Nan
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0] op_a, op_b, spec_val, res_r;
  logic [26:0] big_sig, small_sig, norm_sig;
  logic [27:0] sum_r;
  logic [9:0]  exp_r;
  logic        sign_r, sub_r, spec_r, zero_r;

  always_ff @(posedge Clock) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Go) state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALIGN: unpack, special-case decode and alignment shift
  logic [7:0]  ea_raw, eb_raw, ea, eb, e_big, e_small, diff;
  logic [23:0] sa, sb, s_big, s_small;
  logic [5:0]  sh_al;
  logic [53:0] sh_ext;
  logic        a_big, a_nan, b_nan, a_inf, b_inf, spec_c;
  logic [31:0] spec_c_val;

  always_comb begin
    ea_raw = op_a[30:23];
    eb_raw = op_b[30:23];
    ea     = (ea_raw == 8'd0) ? 8'd1 : ea_raw;
    eb     = (eb_raw == 8'd0) ? 8'd1 : eb_raw;
`ifdef FPADD_FTZ_EN
    sa = (ea_raw == 8'd0) ? 24'd0 : {1'b1, op_a[22:0]};
    sb = (eb_raw == 8'd0) ? 24'd0 : {1'b1, op_b[22:0]};
`else
    sa = {ea_raw != 8'd0, op_a[22:0]};
    sb = {eb_raw != 8'd0, op_b[22:0]};
`endif
    a_big   = op_a[30:0] >= op_b[30:0];
    e_big   = a_big ? ea : eb;
    e_small = a_big ? eb : ea;
    s_big   = a_big ? sa : sb;
    s_small = a_big ? sb : sa;
    diff    = e_big - e_small;
    // Shifts of 27 or more leave only sticky, so clamp before the wide shift
    sh_al   = (diff > 8'd27) ? 6'd27 : diff[5:0];
    sh_ext  = {s_small, 3'b000, 27'd0} >> sh_al;

    a_nan = (ea_raw == 8'hFF) && (op_a[22:0] != 23'd0);
    b_nan = (eb_raw == 8'hFF) && (op_b[22:0] != 23'd0);
    a_inf = (ea_raw == 8'hFF) && (op_a[22:0] == 23'd0);
    b_inf = (eb_raw == 8'hFF) && (op_b[22:0] == 23'd0);
    spec_c     = 1'b1;
    spec_c_val = 32'h7FC00000;
    if (a_nan || b_nan)                         spec_c_val = 32'h7FC00000;
    else if (a_inf && b_inf && (op_a[31] != op_b[31])) spec_c_val = 32'h7FC00000;
    else if (a_inf)                             spec_c_val = op_a;
    else if (b_inf)                             spec_c_val = op_b;
    else                                        spec_c = 1'b0;
  end

  // NORM: leading-zero count, limited so the exponent stays at least 1
  logic [4:0] lz, sh_nm;
  logic [9:0] lim;

  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++)
      if (sum_r[i]) lz = 5'(26 - i);
    lim   = exp_r - 10'd1;
    sh_nm = ({5'd0, lz} > lim) ? lim[4:0] : lz;
  end

  // ROUND: nearest-even on the 24-bit significand plus G/R/S
  logic [24:0] m_rnd;
  logic [9:0]  e_fin;
  logic [22:0] f_fin;
  logic [31:0] res_c;

  always_comb begin
    m_rnd = {1'b0, norm_sig[26:3]} +
            25'(norm_sig[2] & (norm_sig[1] | norm_sig[0] | norm_sig[3]));
    if (m_rnd[24]) begin
      e_fin = exp_r + 10'd1;
      f_fin = m_rnd[23:1];
    end else begin
      e_fin = m_rnd[23] ? exp_r : 10'd0;
      f_fin = m_rnd[22:0];
    end
    if (spec_r)                res_c = spec_val;
    else if (zero_r)           res_c = {sign_r & ~sub_r, 31'd0};
    else if (e_fin >= 10'd255) res_c = {sign_r, 8'hFF, 23'd0};
`ifdef FPADD_FTZ_EN
    else if (e_fin == 10'd0)   res_c = {sign_r, 31'd0};
`endif
    else                       res_c = {sign_r, e_fin[7:0], f_fin};
  end

  always_ff @(posedge Clock) begin
    case (state)
      IDLE: if (Go) begin
        op_a <= AddendA;
        op_b <= AddendB;
      end
      ALIGN: begin
        big_sig   <= {s_big, 3'b000};
        small_sig <= {sh_ext[53:28], sh_ext[27] | (|sh_ext[26:0])};
        exp_r     <= {2'b00, e_big};
        sign_r    <= a_big ? op_a[31] : op_b[31];
        sub_r     <= op_a[31] ^ op_b[31];
        spec_r    <= spec_c;
        spec_val  <= spec_c_val;
      end
      ADD: sum_r <= sub_r ? ({1'b0, big_sig} - {1'b0, small_sig})
                          : ({1'b0, big_sig} + {1'b0, small_sig});
      NORM: begin
        zero_r <= (sum_r == 28'd0);
        if (sum_r[27]) begin
          norm_sig <= {sum_r[27:2], sum_r[1] | sum_r[0]};
          exp_r    <= exp_r + 10'd1;
        end else begin
          norm_sig <= sum_r[26:0] << sh_nm;
          exp_r    <= exp_r - {5'd0, sh_nm};
        end
      end
      ROUND: res_r <= res_c;
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Result <= 32'd0;
      Ready  <= 1'b0;
      Zero   <= 1'b0;
      Inf    <= 1'b0;
      Nan    <= 1'b0;
    end else begin
      Ready <= (state == DONE);
      if (state == DONE) begin
        Result <= res_r;
        Zero   <= (res_r[30:0] == 31'd0);
        Inf    <= (res_r[30:23] == 8'hFF) && (res_r[22:0] == 23'd0);
        Nan    <= (res_r[30:23] == 8'hFF) && (res_r[22:0] != 23'd0);
      end
    end
  end

endmodule

// File: tb/tb_floating_point_adder.sv
// Directed-vector bench for floating_point_adder; expected sums are hand-computed
// bit patterns, flags are packed as {Zero, Inf, Nan}.
module tb_floating_point_adder;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Go = 1'b0;
  logic [31:0] AddendA = 32'd0;
  logic [31:0] AddendB = 32'd0;
  logic [31:0] Result;
  logic        Ready, Zero, Inf, Nan;

  int n_chk  = 0;
  int n_pass = 0;

  floating_point_adder dut (
    .Clock(Clock), .Reset(Reset), .AddendA(AddendA), .AddendB(AddendB), .Go(Go),
    .Result(Result), .Ready(Ready), .Zero(Zero), .Inf(Inf), .Nan(Nan)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [2:0] exp_flg);
    int lat;
    @(negedge Clock);
    AddendA = a;
    AddendB = b;
    Go      = 1'b1;
    @(posedge Clock);
    #1;
    Go      = 1'b0;
    AddendA = ~a;
    AddendB = ~b;
    lat = 0;
    do begin
      @(posedge Clock);
      #1;
      lat++;
    end while (!Ready && lat < 12);
    chk({tag, ".lat"}, 32'(lat), 32'd5);
    chk({tag, ".res"}, Result, exp_res);
    chk({tag, ".flg"}, {29'd0, Zero, Inf, Nan}, {29'd0, exp_flg});
    @(posedge Clock);
    #1;
    chk({tag, ".rdyfall"}, {31'd0, Ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset.res", Result, 32'd0);
    chk("reset.rdy_flg", {28'd0, Ready, Zero, Inf, Nan}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    run_op("negz_posz",  32'h80000000, 32'h00000000, 32'h00000000, 3'b100);
    run_op("negz_negz",  32'h80000000, 32'h80000000, 32'h80000000, 3'b100);
    run_op("max_ovf",    32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b010);
    run_op("nmax_ovf",   32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 3'b010);
    run_op("max_cancel", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00000000, 3'b100);
    run_op("sum_neg",    32'hC36A8F5C, 32'h431C1EB8, 32'hC29CE148, 3'b000);
    run_op("sum_pos",    32'h467441E7, 32'h440DF282, 32'h467D210F, 3'b000);
`ifdef FPADD_FTZ_EN
    run_op("denorm",     32'h00400000, 32'h00400000, 32'h00000000, 3'b100);
`else
    run_op("denorm",     32'h00400000, 32'h00400000, 32'h00800000, 3'b000);
`endif
    run_op("nan_in",     32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b001);
    run_op("inf_minf",   32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b001);
    run_op("inf_fin",    32'h3F800000, 32'hFF800000, 32'hFF800000, 3'b010);
    run_op("tie_even",   32'h3F800000, 32'h33800000, 32'h3F800000, 3'b000);
    run_op("above_tie",  32'h3F800000, 32'h33800001, 32'h3F800001, 3'b000);
    run_op("one_one",    32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000);

    // Reset while in ALIGN aborts the operation
    @(negedge Clock);
    AddendA = 32'h40400000;
    AddendB = 32'h3F000000;
    Go = 1'b1;
    @(posedge Clock);
    #1;
    Go = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    chk("abort.res", Result, 32'd0);
    chk("abort.rdy_flg", {28'd0, Ready, Zero, Inf, Nan}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(posedge Clock);
      #1;
      if (Ready) cnt++;
    end
    chk("abort.no_ready", 32'(cnt), 32'd0);

    // Go held high: second operation captured right after DONE
    @(negedge Clock);
    AddendA = 32'h3F800000;
    AddendB = 32'h3F800000;
    Go = 1'b1;
    @(posedge Clock);
    #1;
    AddendA = 32'h40400000;
    AddendB = 32'h3F000000;
    cnt = 0;
    do begin
      @(posedge Clock);
      #1;
      cnt++;
    end while (!Ready && cnt < 12);
    chk("b2b.lat1", 32'(cnt), 32'd5);
    chk("b2b.res1", Result, 32'h40000000);
    cnt = 0;
    do begin
      @(posedge Clock);
      #1;
      cnt++;
    end while (!Ready && cnt < 12);
    Go = 1'b0;
    chk("b2b.gap", 32'(cnt), 32'd6);
    chk("b2b.res2", Result, 32'h40600000);
    repeat (8) @(posedge Clock);
    #1;
    chk("b2b.hold", Result, 32'h40600000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/floating_point_adder.md
# floating_point_adder

Multi-cycle IEEE-754 single-precision adder. It accepts two `float` operands (`floatingpointpkg` packed struct: sign, 8-bit exponent, 23-bit fraction) on a `Go` request and produces a rounded sum with zero, infinity and NaN status flags. `Ready` signals completion. It serves as the arithmetic datapath block behind the FP test environment and is driven by a simple level-`Go` / pulse-`Ready` handshake.

## Interface
Parameters:
- none; format fixed at binary32 (EXPW=8, FRACW=23, bias 127).

Ports:
- `Clock`: input, 1 bit. Single clock; all state updates on the rising edge.
- `Reset`: input, 1 bit. Synchronous, active-low reset.
- `AddendA`: input, `float` (32 bits). First operand; sampled only at the operand-capture edge.
- `AddendB`: input, `float` (32 bits). Second operand; sampled at the same edge.
- `Go`: input, 1 bit. Start request, level-sensitive, accepted only in IDLE.
- `Result`: output, `float` (32 bits). Registered sum; holds until the next completion.
- `Ready`: output, 1 bit. One-cycle pulse marking that `Result` and the flags are valid.
- `Zero`: output, 1 bit. `Result` is ±0.
- `Inf`: output, 1 bit. `Result` is ±infinity.
- `Nan`: output, 1 bit. `Result` is NaN.

## Operation
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
  - IDLE: if `Go` is high, capture both operands and go to ALIGN; otherwise stay in IDLE.
  - ALIGN → ADD → NORM → ROUND → DONE are unconditional transitions.
  - DONE → IDLE, unconditional.
- Unpack:
  - exp≠0: significand is 1.frac.
  - exp=0: denormal, significand is 0.frac, effective exponent 1.
- ALIGN:
  - Operand with the larger magnitude is the "big" operand.
  - Shift the smaller significand right by the exponent difference into a 27-bit field with guard, round and sticky bits. Shifts ≥27 leave sticky only.
- ADD:
  - Same signs: add magnitudes.
  - Different signs: big minus small.
  - Result sign is the sign of the big operand.
- NORM:
  - Carry-out: shift right 1, exponent +1.
  - Otherwise: left shift by the leading-zero count, single cycle, limited so the exponent does not drop below 1. Hitting the limit produces a denormal.
- ROUND:
  - Round to nearest, ties to even.
  - A rounding carry renormalizes the significand.
  - Exponent reaching 255 gives ±Inf: `Inf`=1, fraction 0.
- Special cases, decided before the arithmetic path and priority-ordered:
  - Either operand NaN → 0x7FC00000, `Nan`=1.
  - +Inf + −Inf → 0x7FC00000, `Nan`=1.
  - Inf + finite, or same-sign Infs → that Inf, `Inf`=1.
- Zero results:
  - Exact cancellation → +0.
  - −0 + −0 → −0.
  - Any ±0 result sets `Zero`=1.
- Exactly one flag may be high at a time.

## Timing
- Reset:
  - When `Reset` is low at a rising edge: state=IDLE, `Result`=0x00000000, `Ready`=0, `Zero`=`Inf`=`Nan`=0.
  - Reset mid-operation aborts the operation. No `Ready` pulse is generated for it.
- Latency:
  - Operands are captured at edge N (IDLE with `Go`=1).
  - `Result` and the flags update, and `Ready` rises, at edge N+5.
  - `Ready` falls at edge N+6.
- Back-to-back operation:
  - If `Go` is still high in the IDLE cycle after DONE, the next operands are captured at edge N+6.
  - Throughput is one result per 6 cycles.
- Input rules:
  - `Go` or operand changes outside IDLE are ignored.
  - Operands need to be stable only at the capture edge.
- `Result` and the flags are held between completions.

## Configuration
- `FPADD_FTZ_EN`: flush-to-zero.
  - Defined: denormal inputs are treated as same-signed zero, and any denormal result becomes signed zero with `Zero`=1.
  - Undefined (default): full gradual-underflow support for denormal inputs and outputs.

## Test plan
- −0 (0x80000000) + +0 (0x00000000) → `Result`=0x00000000, `Zero`=1, `Ready` pulse at N+5.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, `Inf`=1.
- 0xFF7FFFFF + 0xFF7FFFFF → 0xFF800000, `Inf`=1.
- 0x7F7FFFFF + 0xFF7FFFFF → 0x00000000, `Zero`=1.
- Normal-value sums:
  - −234.56 + 156.12 → result bit-exact to `$shortrealtobits` of the shortreal sum.
  - 15632.476 + 567.7892 → result bit-exact to `$shortrealtobits` of the shortreal sum.
  - Flags 0.
- Denormal sum: 0x00400000 + 0x00400000 → 0x00800000.
  - Without `FPADD_FTZ_EN`: 0x00800000, flags 0.
  - With `FPADD_FTZ_EN`: 0x00000000, `Zero`=1.
- NaN input: 0x7FC00000 + 1.0 → 0x7FC00000, `Nan`=1.
- Reset during ALIGN: no `Ready` pulse; outputs are 0 after the reset edge.
